// File: rtl/lc3_mem_responder.sv
// LC-3 memory/device responder: answers the core's memEN/memWE/memRDY handshake.
// It serves a word RAM with programmable wait states and the xFE00 device page
// (KBSR/KBDR/DSR/DDR/MCR). It also generates the registered interrupt request.
module lc3_mem_responder #(
  parameter int unsigned ADDR_W      = 12,
  parameter int unsigned WAIT_STATES = 2,
  parameter logic [7:0]  KBD_VEC     = 8'h80,
  parameter logic [2:0]  KBD_PRI     = 3'd4,
  parameter logic [7:0]  DSP_VEC     = 8'h81,
  parameter logic [2:0]  DSP_PRI     = 3'd3
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] memory_addr,
  input  logic [15:0] memory_din,
  input  logic        memWE,
  input  logic        memEN,
  output logic        memRDY,
  output logic [15:0] memory_dout,
  output logic [15:0] MCR,
  output logic        IRQ,
  output logic [7:0]  INTV,
  output logic [2:0]  INTP,
  input  logic [7:0]  kbd_data,
  input  logic        kbd_valid,
  output logic [7:0]  disp_data,
  output logic        disp_valid,
  input  logic        disp_ack
);

  localparam logic [15:0] KBSR_A = 16'hFE00;
  localparam logic [15:0] KBDR_A = 16'hFE02;
  localparam logic [15:0] DSR_A  = 16'hFE04;
  localparam logic [15:0] DDR_A  = 16'hFE06;
  localparam logic [15:0] MCR_A  = 16'hFFFE;
  localparam logic [3:0]  WAIT_LOAD = (WAIT_STATES == 0) ? 4'd0 : 4'(WAIT_STATES - 1);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP, S_DONE} state_t;

  state_t      state;
  logic [3:0]  cnt;
  logic        live;
  logic [15:0] lat_addr;
  logic [15:0] lat_din;
  logic        lat_we;

  logic        kbd_rdy;
  logic        kbd_ie;
  logic [7:0]  kbdr;
  logic        dsp_rdy;
  logic        dsp_ie;

  logic [15:0] ram [0:(1 << ADDR_W) - 1];

  logic [15:0] acc_addr;
  logic [15:0] acc_din;
  logic        acc_we;
  logic        acc_dev;
  logic        start;
  logic        commit;
  logic        ram_we;
  logic        dev_wr;
  logic        dev_rd;
  logic [ADDR_W-1:0] ram_idx;
  logic [15:0] ram_rdata;
  logic [15:0] dev_rdata;

  // Access operands come straight from the port when completing on the sampling
  // edge, and from the latched copy when completing out of WAIT. Requests are
  // refused until one clock after reset release so that no RAM write slips
  // through while reset is still held.
  always_comb begin
    acc_addr = (state == S_IDLE) ? memory_addr : lat_addr;
    acc_din  = (state == S_IDLE) ? memory_din  : lat_din;
    acc_we   = (state == S_IDLE) ? memWE       : lat_we;
    acc_dev  = (acc_addr[15:9] == 7'h7F);
    start    = (state == S_IDLE) && memEN && live;
    commit   = (start && (acc_dev || (WAIT_STATES == 0))) ||
               ((state == S_WAIT) && (cnt == 4'd0));
    ram_we   = commit && !acc_dev && acc_we;
    dev_wr   = commit && acc_dev && acc_we;
    dev_rd   = commit && acc_dev && !acc_we;
    ram_idx  = acc_addr[ADDR_W-1:0];
    ram_rdata = ram[ram_idx];
  end

  // Device-page read mux; unmapped device addresses read zero.
  always_comb begin
    dev_rdata = '0;
    case (acc_addr)
      KBSR_A:  dev_rdata = {kbd_rdy, kbd_ie, 14'd0};
      KBDR_A:  dev_rdata = {8'h00, kbdr};
      DSR_A:   dev_rdata = {dsp_rdy, dsp_ie, 14'd0};
      MCR_A:   dev_rdata = MCR;
      default: dev_rdata = '0;
    endcase
  end

  // Word RAM storage; not reset.
  always_ff @(posedge clk) begin
    if (ram_we) ram[ram_idx] <= acc_din;
  end

  // Handshake FSM, device registers and read data register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state       <= S_IDLE;
      cnt         <= '0;
      live        <= 1'b0;
      lat_addr    <= '0;
      lat_din     <= '0;
      lat_we      <= 1'b0;
      memRDY      <= 1'b0;
      memory_dout <= '0;
      kbd_rdy     <= 1'b0;
      kbd_ie      <= 1'b0;
      kbdr        <= '0;
      dsp_rdy     <= 1'b1;
      dsp_ie      <= 1'b0;
      MCR         <= 16'h8000;
      disp_data   <= '0;
      disp_valid  <= 1'b0;
    end else begin
      live       <= 1'b1;
      disp_valid <= 1'b0;

      // Later assignments win: a same-cycle kbd_valid beats the KBDR-read clear,
      // and a same-cycle DDR write beats disp_ack.
      if (dev_rd && (acc_addr == KBDR_A)) kbd_rdy <= 1'b0;
      if (kbd_valid) begin
        kbdr    <= kbd_data;
        kbd_rdy <= 1'b1;
      end
      if (disp_ack) dsp_rdy <= 1'b1;
      if (dev_wr) begin
        case (acc_addr)
          KBSR_A: kbd_ie <= acc_din[14];
          DSR_A:  dsp_ie <= acc_din[14];
          DDR_A: begin
            disp_data  <= acc_din[7:0];
            disp_valid <= 1'b1;
            dsp_rdy    <= 1'b0;
          end
          MCR_A:   MCR <= acc_din;
          default: ;
        endcase
      end

      if (commit && !acc_we) memory_dout <= acc_dev ? dev_rdata : ram_rdata;

      case (state)
        S_IDLE: begin
          if (start) begin
            lat_addr <= memory_addr;
            lat_din  <= memory_din;
            lat_we   <= memWE;
            if (commit) begin
              memRDY <= 1'b1;
              state  <= S_RESP;
            end else begin
              cnt   <= WAIT_LOAD;
              state <= S_WAIT;
            end
          end
        end
        S_WAIT: begin
          if (cnt == 4'd0) begin
            memRDY <= 1'b1;
            state  <= S_RESP;
          end else begin
            cnt <= cnt - 4'd1;
          end
        end
        S_RESP: begin
          memRDY <= 1'b0;
          state  <= S_DONE;
        end
        S_DONE: begin
          if (!memEN) state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  // Registered interrupt request; keyboard takes precedence over display.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      IRQ  <= 1'b0;
      INTV <= '0;
      INTP <= '0;
    end else if (kbd_rdy && kbd_ie) begin
      IRQ  <= 1'b1;
      INTV <= KBD_VEC;
      INTP <= KBD_PRI;
    end else if (dsp_rdy && dsp_ie) begin
      IRQ  <= 1'b1;
      INTV <= DSP_VEC;
      INTP <= DSP_PRI;
    end else begin
      IRQ  <= 1'b0;
      INTV <= '0;
      INTP <= '0;
    end
  end

endmodule

// File: tb/tb_lc3_mem_responder.sv
// Directed testbench for lc3_mem_responder (ADDR_W=12, WAIT_STATES=2).
module tb_lc3_mem_responder;

  logic        clk;
  logic        rst;
  logic [15:0] memory_addr;
  logic [15:0] memory_din;
  logic        memWE;
  logic        memEN;
  logic        memRDY;
  logic [15:0] memory_dout;
  logic [15:0] MCR;
  logic        IRQ;
  logic [7:0]  INTV;
  logic [2:0]  INTP;
  logic [7:0]  kbd_data;
  logic        kbd_valid;
  logic [7:0]  disp_data;
  logic        disp_valid;
  logic        disp_ack;

  int checks = 0;
  int errors = 0;
  int dv_cnt = 0;

  lc3_mem_responder #(
    .ADDR_W      (12),
    .WAIT_STATES (2),
    .KBD_VEC     (8'h80),
    .KBD_PRI     (3'd4),
    .DSP_VEC     (8'h81),
    .DSP_PRI     (3'd3)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .memory_addr (memory_addr),
    .memory_din  (memory_din),
    .memWE       (memWE),
    .memEN       (memEN),
    .memRDY      (memRDY),
    .memory_dout (memory_dout),
    .MCR         (MCR),
    .IRQ         (IRQ),
    .INTV        (INTV),
    .INTP        (INTP),
    .kbd_data    (kbd_data),
    .kbd_valid   (kbd_valid),
    .disp_data   (disp_data),
    .disp_valid  (disp_valid),
    .disp_ack    (disp_ack)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Count cycles in which disp_valid is high.
  always @(negedge clk) if (disp_valid) dv_cnt++;

  task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // One complete handshake; lat counts rising edges from the sampling edge
  // through the edge that raises memRDY.
  task automatic access(input logic [15:0] addr, input logic [15:0] din, input logic we,
                        input logic ack, output logic [15:0] rdata, output int lat);
    @(negedge clk);
    memory_addr = addr;
    memory_din  = din;
    memWE       = we;
    memEN       = 1'b1;
    disp_ack    = ack;
    lat   = 0;
    rdata = '0;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk);
      #1;
      disp_ack = 1'b0;
      lat++;
      if (memRDY) break;
    end
    if (!memRDY) check("memrdy_timeout", {15'd0, memRDY}, 16'h0001);
    rdata = memory_dout;
    @(negedge clk);
    memEN = 1'b0;
    @(posedge clk);
    #1;
    check("rdy_one_cycle", {15'd0, memRDY}, 16'h0000);
    @(posedge clk);
  endtask

  task automatic kbd_press(input logic [7:0] ch);
    @(negedge clk);
    kbd_data  = ch;
    kbd_valid = 1'b1;
    @(negedge clk);
    kbd_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
  endtask

  task automatic irq_check(input string tag, input logic irq, input logic [7:0] v, input logic [2:0] p);
    check({tag, "_irq"}, {15'd0, IRQ}, {15'd0, irq});
    check({tag, "_intv"}, {8'd0, INTV}, {8'd0, v});
    check({tag, "_intp"}, {13'd0, INTP}, {13'd0, p});
  endtask

  logic [15:0] rd;
  int          lat;
  logic        saw_rdy;
  int          dv0;

  initial begin
    rst = 1'b0; memory_addr = '0; memory_din = '0; memWE = 1'b0; memEN = 1'b0;
    kbd_data = '0; kbd_valid = 1'b0; disp_ack = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_memrdy", {15'd0, memRDY}, 16'h0000);
    check("rst_dout", memory_dout, 16'h0000);
    check("rst_mcr", MCR, 16'h8000);
    check("rst_disp", {7'd0, disp_valid, disp_data}, 16'h0000);
    irq_check("rst", 1'b0, 8'h00, 3'd0);
    @(negedge clk); rst = 1'b1;
    repeat (2) @(posedge clk);

    // RAM latency and data
    access(16'h3000, 16'h1234, 1'b1, 1'b0, rd, lat);
    check("ram_wr_lat", 16'(lat), 16'd3);
    access(16'h3000, 16'h0000, 1'b0, 1'b0, rd, lat);
    check("ram_rd_lat", 16'(lat), 16'd3);
    check("ram_rd_data", rd, 16'h1234);

    // Aliasing across 2**ADDR_W
    access(16'h3000, 16'hBEEF, 1'b1, 1'b0, rd, lat);
    access(16'h3000, 16'h0000, 1'b0, 1'b0, rd, lat);
    check("alias_base", rd, 16'hBEEF);
    access(16'h4000, 16'h0000, 1'b0, 1'b0, rd, lat);
    check("alias_hi", rd, 16'hBEEF);

    // Device reset values
    access(16'hFE00, 16'h0000, 1'b0, 1'b0, rd, lat);
    check("kbsr_init", rd, 16'h0000);
    check("dev_rd_lat", 16'(lat), 16'd1);
    access(16'hFE04, 16'h0000, 1'b0, 1'b0, rd, lat);
    check("dsr_init", rd, 16'h8000);

    // Keyboard
    access(16'hFE00, 16'hFFFF, 1'b1, 1'b0, rd, lat);
    kbd_press(8'h41);
    irq_check("kbd", 1'b1, 8'h80, 3'd4);
    access(16'hFE00, 16'h0000, 1'b0, 1'b0, rd, lat);
    check("kbsr_ready", rd, 16'hC000);
    access(16'hFE02, 16'h0000, 1'b0, 1'b0, rd, lat);
    check("kbdr_data", rd, 16'h0041);
    access(16'hFE00, 16'h0000, 1'b0, 1'b0, rd, lat);
    check("kbsr_cleared", rd, 16'h4000);
    irq_check("kbd_clr", 1'b0, 8'h00, 3'd0);

    // Display
    dv0 = dv_cnt;
    access(16'hFE06, 16'h0058, 1'b1, 1'b0, rd, lat);
    check("disp_valid_pulses", 16'(dv_cnt - dv0), 16'd1);
    check("disp_data", {8'd0, disp_data}, 16'h0058);
    access(16'hFE06, 16'h0000, 1'b0, 1'b0, rd, lat);
    check("ddr_read", rd, 16'h0000);
    access(16'hFE04, 16'h0000, 1'b0, 1'b0, rd, lat);
    check("dsr_busy", rd, 16'h0000);
    @(negedge clk); disp_ack = 1'b1;
    @(negedge clk); disp_ack = 1'b0;
    access(16'hFE04, 16'h0000, 1'b0, 1'b0, rd, lat);
    check("dsr_acked", rd, 16'h8000);

    // Display interrupt, then keyboard precedence
    access(16'hFE04, 16'h4000, 1'b1, 1'b0, rd, lat);
    access(16'hFE04, 16'h0000, 1'b0, 1'b0, rd, lat);
    check("dsr_ie", rd, 16'hC000);
    irq_check("dsp", 1'b1, 8'h81, 3'd3);
    kbd_press(8'h5A);
    irq_check("prio", 1'b1, 8'h80, 3'd4);
    access(16'hFE02, 16'h0000, 1'b0, 1'b0, rd, lat);
    check("kbdr_data2", rd, 16'h005A);
    irq_check("dsp_again", 1'b1, 8'h81, 3'd3);

    // Ack and DDR write in the same cycle: write wins
    access(16'hFE04, 16'h0000, 1'b1, 1'b0, rd, lat);
    access(16'hFE06, 16'h0033, 1'b1, 1'b1, rd, lat);
    access(16'hFE04, 16'h0000, 1'b0, 1'b0, rd, lat);
    check("ack_vs_ddr", rd, 16'h0000);
    irq_check("idle", 1'b0, 8'h00, 3'd0);

    // Unmapped device address and MCR
    access(16'hFE10, 16'h0000, 1'b0, 1'b0, rd, lat);
    check("unmapped_rd", rd, 16'h0000);
    access(16'hFFFE, 16'h0000, 1'b1, 1'b0, rd, lat);
    check("mcr_wr_lat", 16'(lat), 16'd1);
    check("mcr_halt", MCR, 16'h0000);

    // Reset during WAIT of a RAM write aborts it
    @(negedge clk);
    memory_addr = 16'h3000; memory_din = 16'h7777; memWE = 1'b1; memEN = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0; memEN = 1'b0;
    saw_rdy = 1'b0;
    repeat (4) begin
      @(negedge clk);
      saw_rdy = saw_rdy | memRDY;
    end
    rst = 1'b1;
    repeat (3) begin
      @(negedge clk);
      saw_rdy = saw_rdy | memRDY;
    end
    check("abort_no_rdy", {15'd0, saw_rdy}, 16'h0000);
    check("mcr_after_rst", MCR, 16'h8000);
    access(16'h3000, 16'h0000, 1'b0, 1'b0, rd, lat);
    check("abort_no_write", rd, 16'hBEEF);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
